// File: rtl/mask_stream_gen.sv
`default_nettype none
// ============================================================================
// Module   : mask_stream_gen
// Purpose  : Raster timing and binary test-mask source (zero, checker, box,
//            LFSR noise) for the mask-domain filters. Registered outputs.
// Option   : define MASK_GEN_LFSR_RESEED_EN to reseed the LFSR every frame.
// Revision : 1.0
// ============================================================================
module mask_stream_gen #(
  parameter int          H_ACTIVE  = 64,
  parameter int          H_FP      = 4,
  parameter int          H_SYNC    = 8,
  parameter int          H_BP      = 7,
  parameter int          V_ACTIVE  = 64,
  parameter int          V_FP      = 2,
  parameter int          V_SYNC    = 2,
  parameter int          V_BP      = 4,
  parameter int          CELL_LOG2 = 3,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] mode,
  input  logic [7:0] density,
  output logic       de_out,
  output logic       h_sync_out,
  output logic       v_sync_out,
  output logic       mask_out,
  output logic       frame_start,
  output logic       busy
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] c_h_last  = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] c_v_last  = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] c_h_act   = HW'(H_ACTIVE);
  localparam logic [VW-1:0] c_v_act   = VW'(V_ACTIVE);
  localparam logic [HW-1:0] c_hs_beg  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] c_hs_end  = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] c_vs_beg  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] c_vs_end  = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [HW-1:0] c_bx_h_lo = HW'(H_ACTIVE / 4);
  localparam logic [HW-1:0] c_bx_h_hi = HW'(3 * H_ACTIVE / 4);
  localparam logic [VW-1:0] c_bx_v_lo = VW'(V_ACTIVE / 4);
  localparam logic [VW-1:0] c_bx_v_hi = VW'(3 * V_ACTIVE / 4);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_run  = 2'd1;
  localparam logic [1:0] c_st_stop = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [1:0]    mode_q, mode_d;
  logic          de_q, de_d, hs_q, hs_d, vs_q, vs_d;
  logic          mask_q, mask_d, fs_q, fs_d, busy_q, busy_d;

  logic w_running, w_h_wrap, w_frame_wrap, w_active, w_lfsr_fb;

  assign w_running    = (state_q != c_st_idle);
  assign w_h_wrap     = (h_q == c_h_last);
  assign w_frame_wrap = w_h_wrap && (v_q == c_v_last);
  assign w_active     = (h_q < c_h_act) && (v_q < c_v_act);
  assign w_lfsr_fb    = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= c_st_idle;
      h_q     <= '0;
      v_q     <= '0;
      lfsr_q  <= LFSR_SEED;
      mode_q  <= 2'd0;
      de_q    <= 1'b0;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      mask_q  <= 1'b0;
      fs_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
      lfsr_q  <= lfsr_d;
      mode_q  <= mode_d;
      de_q    <= de_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      mask_q  <= mask_d;
      fs_q    <= fs_d;
      busy_q  <= busy_d;
    end
  end

  // Next state, counters, mode latch and LFSR advance.
  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    lfsr_d  = lfsr_q;
    mode_d  = mode_q;
    case (state_q)
      c_st_idle: begin
        h_d = '0;
        v_d = '0;
        if (en) begin
          state_d = c_st_run;
          mode_d  = mode;
`ifdef MASK_GEN_LFSR_RESEED_EN
          lfsr_d  = LFSR_SEED;
`endif
        end
      end
      c_st_run, c_st_stop: begin
        if (w_h_wrap) begin
          h_d = '0;
          v_d = (v_q == c_v_last) ? '0 : v_q + VW'(1);
        end else begin
          h_d = h_q + HW'(1);
        end
        if (w_active) begin
          lfsr_d = {w_lfsr_fb, lfsr_q[15:1]};
        end
        // A frame is always completed; stopping only takes effect at the wrap.
        if (w_frame_wrap) begin
`ifdef MASK_GEN_LFSR_RESEED_EN
          lfsr_d = LFSR_SEED;
`endif
          if ((state_q == c_st_run) && en) begin
            mode_d = mode;
          end else begin
            state_d = c_st_idle;
          end
        end else if ((state_q == c_st_run) && !en) begin
          state_d = c_st_stop;
        end
      end
      default: state_d = c_st_idle;
    endcase
  end

  // Output decode for the current counter position, registered next edge.
  always_comb begin
    de_d   = 1'b0;
    hs_d   = 1'b0;
    vs_d   = 1'b0;
    mask_d = 1'b0;
    fs_d   = 1'b0;
    busy_d = (state_d != c_st_idle);
    if (w_running) begin
      de_d = w_active;
      hs_d = (h_q >= c_hs_beg) && (h_q < c_hs_end);
      vs_d = (v_q >= c_vs_beg) && (v_q < c_vs_end);
      fs_d = (h_q == '0) && (v_q == '0);
      if (w_active) begin
        case (mode_q)
          2'd1:    mask_d = h_q[CELL_LOG2] ^ v_q[CELL_LOG2];
          2'd2:    mask_d = (h_q >= c_bx_h_lo) && (h_q < c_bx_h_hi) &&
                            (v_q >= c_bx_v_lo) && (v_q < c_bx_v_hi);
          2'd3:    mask_d = (lfsr_q[7:0] < density);
          default: mask_d = 1'b0;
        endcase
      end
    end
  end

  assign de_out      = de_q;
  assign h_sync_out  = hs_q;
  assign v_sync_out  = vs_q;
  assign mask_out    = mask_q;
  assign frame_start = fs_q;
  assign busy        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_mask_stream_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_mask_stream_gen
// Purpose  : Directed self-checking bench for mask_stream_gen.
// Revision : 1.0
// ============================================================================
module tb_mask_stream_gen;

  localparam int c_frame = 83 * 72;

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic [7:0] density;
  logic       de_out, h_sync_out, v_sync_out, mask_out, frame_start, busy;

  int          n_cmp;
  int          n_err;
  logic [15:0] m_lfsr;
  int          ones_a, ones_b, first_one;

  mask_stream_gen dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .mode        (mode),
    .density     (density),
    .de_out      (de_out),
    .h_sync_out  (h_sync_out),
    .v_sync_out  (v_sync_out),
    .mask_out    (mask_out),
    .frame_start (frame_start),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Samples one whole frame pixel by pixel against a reference raster/mask model.
  task automatic measure_frame(input string tag, input logic [1:0] exp_mode,
                               input logic [1:0] nxt_mode, input logic [7:0] nxt_density,
                               input bit drop_en, output int ones, output int first);
    int   de_n, hs_n, vs_n, de_e, hs_e, vs_e, mk_e, fs_e, bz_e, h, v;
    logic e_de, e_hs, e_vs, e_mk, e_bz;
    logic [7:0] dens;
    for (int i = 0; i < 7000 && frame_start !== 1'b1; i++) @(negedge clk);
    check_eq({tag, "_fs_seen"}, 32'(frame_start), 32'd1);
`ifdef MASK_GEN_LFSR_RESEED_EN
    m_lfsr = 16'hACE1;
`endif
    dens = density;
    de_n = 0; hs_n = 0; vs_n = 0; de_e = 0; hs_e = 0; vs_e = 0;
    mk_e = 0; fs_e = 0; bz_e = 0; ones = 0; first = -1;
    for (int k = 0; k < c_frame; k++) begin
      h    = k % 83;
      v    = k / 83;
      e_de = (h < 64) && (v < 64);
      e_hs = (h >= 68) && (h < 76);
      e_vs = (v >= 66) && (v < 68);
      e_bz = !(drop_en && k == c_frame - 1);
      e_mk = 1'b0;
      if (e_de) begin
        case (exp_mode)
          2'd1: e_mk = ((h >> 3) ^ (v >> 3)) & 1;
          2'd2: e_mk = (h >= 16) && (h < 48) && (v >= 16) && (v < 48);
          2'd3: e_mk = (m_lfsr[7:0] < dens);
          default: e_mk = 1'b0;
        endcase
        m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
      end
      if (de_out !== e_de) de_e++;
      if (h_sync_out !== e_hs) hs_e++;
      if (v_sync_out !== e_vs) vs_e++;
      if (mask_out !== e_mk) mk_e++;
      if (frame_start !== (k == 0)) fs_e++;
      if (busy !== e_bz) bz_e++;
      if (de_out === 1'b1) de_n++;
      if (h_sync_out === 1'b1) hs_n++;
      if (v_sync_out === 1'b1) vs_n++;
      if (mask_out === 1'b1) begin
        ones++;
        if (first < 0) first = k;
      end
      if (k == 1) mode = nxt_mode;
      if (k == c_frame - 1) density = nxt_density;
      if (drop_en && k == 20 * 83 + 10) en = 1'b0;
      @(negedge clk);
    end
    check_eq({tag, "_de_err"},   32'(de_e), 32'd0);
    check_eq({tag, "_hs_err"},   32'(hs_e), 32'd0);
    check_eq({tag, "_vs_err"},   32'(vs_e), 32'd0);
    check_eq({tag, "_mask_err"}, 32'(mk_e), 32'd0);
    check_eq({tag, "_fs_err"},   32'(fs_e), 32'd0);
    check_eq({tag, "_busy_err"}, 32'(bz_e), 32'd0);
    check_eq({tag, "_de_cnt"},   32'(de_n), 32'd4096);
    check_eq({tag, "_hs_cnt"},   32'(hs_n), 32'd576);
    check_eq({tag, "_vs_cnt"},   32'(vs_n), 32'd166);
    check_eq({tag, "_next_fs"},  32'(frame_start), drop_en ? 32'd0 : 32'd1);
  endtask

  initial begin
    int hi_n;
    n_cmp   = 0;
    n_err   = 0;
    m_lfsr  = 16'hACE1;
    rst     = 1'b0;
    en      = 1'b0;
    mode    = 2'd0;
    density = 8'd0;
    #2 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_de",   32'(de_out),      32'd0);
    check_eq("rst_hs",   32'(h_sync_out),  32'd0);
    check_eq("rst_vs",   32'(v_sync_out),  32'd0);
    check_eq("rst_mask", 32'(mask_out),    32'd0);
    check_eq("rst_fs",   32'(frame_start), 32'd0);
    check_eq("rst_busy", 32'(busy),        32'd0);
    rst = 1'b0;
    @(negedge clk);

    // en glitch inside IDLE with no clock edge in between
    en = 1'b1;
    #1 en = 1'b0;
    @(negedge clk);
    check_eq("glitch_busy", 32'(busy), 32'd0);

    en = 1'b1;
    @(negedge clk);
    check_eq("start_busy", 32'(busy),   32'd1);
    check_eq("start_de0",  32'(de_out), 32'd0);
    @(negedge clk);
    check_eq("start_de1",  32'(de_out),      32'd1);
    check_eq("start_fs",   32'(frame_start), 32'd1);

    measure_frame("f1_m0", 2'd0, 2'd0, 8'd0, 1'b0, ones_a, first_one);
    check_eq("f1_ones", 32'(ones_a), 32'd0);
    measure_frame("f2_m0", 2'd0, 2'd1, 8'd0, 1'b0, ones_a, first_one);
    check_eq("f2_ones", 32'(ones_a), 32'd0);
    measure_frame("f3_m1", 2'd1, 2'd2, 8'd0, 1'b0, ones_a, first_one);
    check_eq("f3_ones",  32'(ones_a),    32'd2048);
    check_eq("f3_first", 32'(first_one), 32'd8);
    measure_frame("f4_m2", 2'd2, 2'd3, 8'd0, 1'b0, ones_a, first_one);
    check_eq("f4_ones",  32'(ones_a),    32'd1024);
    check_eq("f4_first", 32'(first_one), 32'(16 * 83 + 16));
    measure_frame("f5_d0", 2'd3, 2'd3, 8'd255, 1'b0, ones_a, first_one);
    check_eq("f5_ones", 32'(ones_a), 32'd0);
    measure_frame("f6_d255", 2'd3, 2'd3, 8'd255, 1'b0, ones_a, first_one);
    measure_frame("f7_d255", 2'd3, 2'd1, 8'd0, 1'b0, ones_b, first_one);
`ifdef MASK_GEN_LFSR_RESEED_EN
    check_eq("reseed_same", 32'(ones_b), 32'(ones_a));
`endif

    // en removed at pixel (10,20): frame must still complete
    measure_frame("f8_stop", 2'd1, 2'd1, 8'd0, 1'b1, ones_a, first_one);
    check_eq("f8_ones", 32'(ones_a), 32'd2048);
    check_eq("stop_busy", 32'(busy), 32'd0);
    hi_n = 0;
    for (int i = 0; i < 100; i++) begin
      if ((de_out | h_sync_out | v_sync_out | mask_out | frame_start | busy) !== 1'b0) hi_n++;
      @(negedge clk);
    end
    check_eq("idle_quiet", 32'(hi_n), 32'd0);

    // async reset while de_out is high
    en = 1'b1;
    for (int i = 0; i < 10 && frame_start !== 1'b1; i++) @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check_eq("pre_rst_de", 32'(de_out), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_de",   32'(de_out),     32'd0);
    check_eq("arst_hs",   32'(h_sync_out), 32'd0);
    check_eq("arst_vs",   32'(v_sync_out), 32'd0);
    check_eq("arst_mask", 32'(mask_out),   32'd0);
    check_eq("arst_busy", 32'(busy),       32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rel_fs0", 32'(frame_start), 32'd0);
    @(negedge clk);
    check_eq("rel_fs1", 32'(frame_start), 32'd1);
    check_eq("rel_de1", 32'(de_out),      32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mask_stream_gen.md
Name: mask_stream_gen

Overview:
- Video timing and binary-mask source that drives the 4-bit mask/de/h_sync/v_sync stream consumed by the mask-domain filters, e.g. the 5x5 median.
- Generates raster timing from parameters and a selectable mask test pattern, including salt-and-pepper noise for filter bring-up.
- Sits where the camera/threshold front end normally connects.
- Outputs are fully registered.

Parameters:
- H_ACTIVE, 64, active pixels per line
- H_FP, 4, horizontal front porch (clocks)
- H_SYNC, 8, h_sync width (clocks)
- H_BP, 7, horizontal back porch; H_TOTAL = 83
- V_ACTIVE, 64, active lines per frame
- V_FP, 2, vertical front porch (lines)
- V_SYNC, 2, v_sync width (lines)
- V_BP, 4, vertical back porch; V_TOTAL = 72
- CELL_LOG2, 3, checkerboard cell size is 2^CELL_LOG2 pixels
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous reset, active-high
- en  in  1  run request
- mode  in  2  pattern: 0 all-zero, 1 checkerboard, 2 centre box, 3 noise
- density  in  8  noise threshold
- de_out  out  1  data enable
- h_sync_out  out  1  horizontal sync, active-high
- v_sync_out  out  1  vertical sync, active-high
- mask_out  out  1  mask bit
- frame_start  out  1  one-cycle pulse, coincident with the first de_out of a frame
- busy  out  1  high while in RUN or STOPPING

Behaviour:
- Reset values:
  - All outputs 0.
  - FSM in IDLE; h_cnt = v_cnt = 0; lfsr = LFSR_SEED; mode_q = 0.
- FSM states:
  - IDLE: counters held at 0; outputs 0. On en = 1, go to RUN and latch mode into mode_q.
  - RUN: counters advance every clock.
    - h_cnt wraps at H_TOTAL-1; v_cnt increments on each h wrap and wraps at V_TOTAL-1.
    - At a frame wrap (h_cnt = H_TOTAL-1 and v_cnt = V_TOTAL-1): if en = 1, re-latch mode; if en = 0, go to IDLE.
    - If en drops mid-frame, go to STOPPING.
  - STOPPING: identical to RUN, but at the frame wrap go to IDLE regardless of en. A frame is never truncated.
- Counter/pixel relationship: the counter value is (0,0) on the first RUN clock. Outputs for counter (h,v) appear one clock later.
  - So de_out first rises 2 clocks after en is sampled high in IDLE.
- Decode from the counters:
  - active = (h_cnt < H_ACTIVE) and (v_cnt < V_ACTIVE).
  - h_sync while H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, on every line.
  - v_sync for whole lines while V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC.
  - de_out = active.
- Mask, forced to 0 when not active:
  - mode 0: 0.
  - mode 1: h_cnt[CELL_LOG2] XOR v_cnt[CELL_LOG2].
  - mode 2: 1 when H_ACTIVE/4 <= h_cnt < 3*H_ACTIVE/4 and V_ACTIVE/4 <= v_cnt < 3*V_ACTIVE/4.
  - mode 3: 1 when lfsr[7:0] < density.
    - density = 0 gives an all-zero mask; density = 255 gives ~255/256 ones.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11.
  - Shifts once per active pixel in every mode.
  - Does not shift in IDLE or during blanking.
- Mode changes mid-frame take no effect until the next frame boundary.
- Asynchronous reset mid-frame: all state returns to reset values immediately and outputs go to 0 without waiting for a clock.
- en toggling high then low within IDLE with no clock edge between: no effect.

Optional Feature:
- Macro: MASK_GEN_LFSR_RESEED_EN.
- Defined: lfsr is reloaded with LFSR_SEED at every frame wrap and on IDLE->RUN, so every noise frame is bit-identical.
- Undefined: lfsr free-runs across frames and is seeded only by reset.

Test Plan:
- Reset, en = 1, mode = 0, run 2 frames:
  - de_out high exactly 64 clocks per line and 64 lines per frame; 4096 de clocks per frame.
  - h_sync high 8 clocks, starting 4 clocks after de falls.
  - frame period 83*72 = 5976 clocks.
  - mask_out always 0.
- mode = 1, CELL_LOG2 = 3: line 0 mask is 8 zeros, 8 ones, repeating; line 8 is inverted.
- mode = 2: per frame, ones count = 32*32 = 1024, first one at pixel (16,16).
- mode = 3, density = 0 then 255:
  - density = 0: 0 ones.
  - density = 255: ones count equals a reference-model count from the same LFSR sequence, about 4080.
  - Macro defined: two consecutive frames compare identical.
- en dropped at pixel (10,20): current frame completes all 72 lines, busy falls after the wrap, then outputs stay 0.
- rst asserted mid-line with de_out = 1: de_out, h_sync_out, v_sync_out and mask_out drop to 0 asynchronously; after release with en = 1, frame_start fires 2 clocks later.
